// File: rtl/gpio_cfg_pkg.sv
// Shared types and serial-chain timing constants for the GPIO configuration transmitter.
package gpio_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_LOAD  = 3'd4,
    ST_DONE  = 3'd5
  } cfg_state_e;

  // The latch strobe spans this many serial_clock half-periods.
  localparam int LOAD_HALF_PERIODS = 2;

  // Width of a counter that runs 0..terminal-1 and wraps; never narrower than 1 bit.
  function automatic int cnt_width(input int terminal);
    return (terminal < 2) ? 1 : $clog2(terminal);
  endfunction

endpackage

// File: rtl/gpio_cfg_clkdiv.sv
// Serial clock divider: CLK_DIV cycles low, CLK_DIV cycles high per bit.
// Held at the start of the low phase whenever en is low, so every bit begins low.
module gpio_cfg_clkdiv
  import gpio_cfg_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic low_phase,
  output logic high_phase,
  output logic bit_end
);

  localparam int DW = cnt_width(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          phase;
  logic          half_end;

  assign half_end = (div_cnt == DIV_LAST);

  // Half-period counter; phase flips and the counter wraps at the terminal count.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (half_end) begin
      div_cnt <= '0;
      phase   <= ~phase;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // phase is a flop, so high_phase can drive the chain clock directly without glitches.
  assign low_phase  = en & ~phase;
  assign high_phase = phase;
  assign bit_end    = en & phase & half_end;

endmodule

// File: rtl/gpio_cfg_xmit.sv
// Streams one CFG_BITS word per pad (highest pad first, MSB first) into the GPIO
// configuration chain, then pulses serial_load to latch the chain.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; chain outputs all low
// ST_FETCH | cfg_rd_addr presents the current pad
// ST_WAIT  | read data arrives; captured into the shift register at end
// ST_SHIFT | shifting the word out, 2*CLK_DIV cycles per bit
// ST_LOAD  | serial_load high for 2*CLK_DIV cycles, serial_clock low
// ST_DONE  | one-cycle done pulse
module gpio_cfg_xmit
  import gpio_cfg_pkg::*;
#(
  parameter int NUM_PADS = 38,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV  = 4,
  localparam int AW      = cnt_width(NUM_PADS)
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       cfg_rd_addr,
  input  logic [CFG_BITS-1:0] cfg_rd_data,
  output logic                serial_clock,
  output logic                serial_data_out,
  output logic                serial_load
);

  localparam int LOAD_LEN = LOAD_HALF_PERIODS * CLK_DIV;
  localparam int BW       = cnt_width(CFG_BITS);
  localparam int LW       = cnt_width(LOAD_LEN);

  localparam logic [AW-1:0] PAD_FIRST = AW'(NUM_PADS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CFG_BITS - 1);
  localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_LEN - 1);

  cfg_state_e          state;
  cfg_state_e          state_nxt;
  logic [AW-1:0]       pad_idx;
  logic [BW-1:0]       bit_cnt;
  logic [LW-1:0]       load_cnt;
  logic [CFG_BITS-1:0] shreg;
  logic                load_q;

  logic shift_en;
  logic low_phase;
  logic high_phase;
  logic bit_end;
  logic last_bit;
  logic load_last;

  assign shift_en  = (state == ST_SHIFT);
  assign last_bit  = (bit_cnt == BIT_LAST);
  assign load_last = (load_cnt == LOAD_LAST);

  gpio_cfg_clkdiv #(
    .CLK_DIV (CLK_DIV)
  ) u_clkdiv (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .en         (shift_en),
    .low_phase  (low_phase),
    .high_phase (high_phase),
    .bit_end    (bit_end)
  );

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_FETCH;
      end
      ST_FETCH: state_nxt = ST_WAIT;
      ST_WAIT:  state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (bit_end && last_bit) state_nxt = (pad_idx == '0) ? ST_LOAD : ST_FETCH;
      end
      ST_LOAD: begin
        if (load_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pad/bit/load counters and the shift register. The register drains to zero
  // by the end of each word, which keeps serial_data_out low between words.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pad_idx  <= '0;
      bit_cnt  <= '0;
      load_cnt <= '0;
      shreg    <= '0;
      load_q   <= 1'b0;
    end else begin
      load_q <= (state_nxt == ST_LOAD);
      unique case (state)
        ST_IDLE: begin
          if (start) pad_idx <= PAD_FIRST;
        end
        ST_WAIT: shreg <= cfg_rd_data;
        ST_SHIFT: begin
          if (bit_end) begin
            shreg <= shreg << 1;
            if (last_bit) begin
              bit_cnt <= '0;
              if (pad_idx != '0) pad_idx <= pad_idx - 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_LOAD: load_cnt <= load_last ? '0 : load_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // The data line is only driven while the divider is active; it changes at the
  // end of a high phase, so it is stable throughout the following high phase.
  assign cfg_rd_addr     = pad_idx;
  assign serial_clock    = high_phase;
  assign serial_data_out = shreg[CFG_BITS-1] & (low_phase | high_phase);
  assign serial_load     = load_q;

endmodule
